spi_master: RTL
===============

Name: spi_master

Overview:
- SPI mode-0 initiator that drives one two-byte memory transaction to the SPI peripheral's shift register. Byte 0 is the command byte, byte 1 is the data byte.
- Sits between the FPGA-side test logic and the off-block SPI pins (sclk, cs, mosi, miso). It generates the serial clock from the FPGA clock.
- A single start pulse runs a full 16-bit frame. Completion is flagged with a one-cycle done pulse, plus read data for read transactions.

Parameters:
- width, 8, bits per byte; the frame is 2*width bits.
- clkdiv, 4, FPGA clock cycles per sclk half-period; must be at least 2.

Ports:
- clk  input  1  FPGA clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a transaction; sampled only while busy=0.
- rw  input  1  1 = write, 0 = read; latched at start.
- addr  input  width-1  target address; latched at start.
- wdata  input  width  write data; latched at start.
- busy  output  1  high from start acceptance until the end of the inter-frame gap.
- done  output  1  one-cycle pulse when cs deasserts; rdata is valid in that cycle.
- rdata  output  width  byte read from miso.
- sclk  output  1  serial clock; idles low.
- cs  output  1  chip select, active low; idles high.
- mosi  output  1  serial data to peripheral, MSB first.
- miso  input  1  serial data from peripheral.

Behaviour:
- Reset (asynchronous, takes effect immediately even mid-frame): cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0, state IDLE, all counters cleared.
- Frame layout: shift word = {rw, addr, wdata} for a write and {rw, addr, zeros} for a read. It is shifted MSB first.
- States are IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: outputs are at their idle values. When start=1, rw/addr/wdata are latched at that edge (edge 0).
- Edge 0 → SETUP: busy=1, cs=0, mosi = frame bit 2*width-1.
- Edge clkdiv → SHIFT: sclk rises. Bit k rises at edge (2k-1)*clkdiv and falls at edge 2k*clkdiv, for k = 1 .. 2*width.
- Sampling: miso is sampled at each edge that raises sclk.
- mosi update: mosi changes only at the edges that lower sclk, except the final one. It is never updated on a rising edge.
- Read capture: the bits sampled on rising edges width+1 .. 2*width fill a receive register MSB first. Bits sampled during byte 0 are discarded.
- Last falling edge (edge 2*2*width*clkdiv) → HOLD: sclk=0, cs stays 0, mosi=0, for clkdiv cycles.
- Edge (4*width+1)*clkdiv → GAP: cs=1 and done=1 for exactly one cycle. For a read, rdata updates in the same cycle. For a write, rdata keeps its previous value.
- GAP lasts clkdiv cycles with busy=1. Then busy=0 and state IDLE, at edge (4*width+2)*clkdiv. Minimum cs-high time is therefore clkdiv cycles.
- start asserted while busy=1 is ignored; it is not queued.
- start in the first cycle busy=0 is accepted.
- Input changes after edge 0 do not affect the frame in progress.
- Example, width=8, clkdiv=4: done at edge 132, busy low at edge 136.

Decomposition:
- Shared package spi_pkg holds:
  - state encoding constants IDLE/SETUP/SHIFT/HOLD/GAP;
  - FRAME_BITS = 2*width;
  - the write-flag bit position (MSB of the command byte, 1 = write), shared with the peripheral side.
- Sub-module spi_clkgen: a half-period counter that emits one-cycle rise_tick/fall_tick strobes and the registered sclk. It is enabled only in SHIFT.
- The FSM, bit counter, and transmit/receive shift registers stay in spi_master.

Test Plan (width=8, clkdiv=2 unless stated):
- Reset: assert reset asynchronously between clock edges → cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0 before the next clk edge.
- Write: start, rw=1, addr=0x15, wdata=0xA5 → the 16 mosi bits sampled on sclk rises equal 0x95A5; exactly 16 sclk pulses; done at edge 66, busy low at edge 68; rdata unchanged.
- Read: rw=0, addr=0x15; peripheral model drives 0x3C on miso, changing on sclk falls during byte 1 → mosi bits = 0x1500; rdata=0x3C in the done cycle.
- Start while busy: pulse start at edges 10 and 67 → both ignored, no second frame. Pulse start at edge 68 → accepted; cs was high for exactly 2 cycles between frames.
- Reset mid-frame: assert reset after the 5th sclk rise → immediate cs=1, sclk=0, busy=0. After release, a fresh write of 0x95A5 completes normally.
- clkdiv=4 write: done at edge 132, busy low at edge 136, and each sclk high/low phase lasts exactly 4 cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, frame geometry and write-flag position.
package spi_pkg;

    localparam int SPI_WIDTH  = 8;
    localparam int SPI_CLKDIV = 4;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    function automatic int frame_bits(input int w);
        return 2 * w;
    endfunction

    // Frame bit carrying the write flag (MSB of the command byte, 1 = write).
    function automatic int wr_flag_bit(input int w);
        return 2 * w - 1;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period counter producing sclk plus one-cycle strobes for the edge that raises or lowers it.
module spi_clkgen #(
    parameter int CLKDIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic launch_i,
    output logic rise_tick_o,
    output logic fall_tick_o,
    output logic sclk_o
);
    localparam int CW = $clog2(CLKDIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKDIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          wrap_s;

    // Strobes are asserted in the cycle before the edge that moves sclk.
    always_comb begin
        wrap_s      = en_i && (cnt_q == CNT_MAX);
        rise_tick_o = launch_i || (wrap_s && !sclk_q);
        fall_tick_o = wrap_s && sclk_q;
        if (en_i && !wrap_s) begin
            cnt_d = cnt_q + CW'(1'b1);
        end else begin
            cnt_d = {CW{1'b0}};
        end
        if (rise_tick_o) begin
            sclk_d = 1'b1;
        end else if (fall_tick_o) begin
            sclk_d = 1'b0;
        end else begin
            sclk_d = sclk_q;
        end
    end

    // Counter and sclk registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= {CW{1'b0}};
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one {command, data} frame per accepted start, sequenced SETUP, SHIFT, HOLD, GAP.
// The GAP guarantees clkdiv cycles of cs high; a start on its last cycle chains straight into SETUP.
module spi_master
    import spi_pkg::*;
#(
    parameter int width  = SPI_WIDTH,
    parameter int clkdiv = SPI_CLKDIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rw,
    input  logic [width-2:0] addr,
    input  logic [width-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] rdata,
    output logic             sclk,
    output logic             cs,
    output logic             mosi,
    input  logic             miso
);
    localparam int FRAME_BITS = frame_bits(width);
    localparam int WR_BIT     = wr_flag_bit(width);
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int CW         = $clog2(clkdiv);
    localparam logic [CW-1:0] WAIT_MAX = CW'(clkdiv - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] RX_FIRST = BW'(width);

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         wait_q, wait_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [width-1:0]      rx_q, rx_d;
    logic [width-1:0]      rdata_q, rdata_d;
    logic                  rw_q, rw_d;
    logic                  busy_q, busy_d;
    logic                  cs_q, cs_d;
    logic                  mosi_q, mosi_d;
    logic                  done_q, done_d;

    logic [FRAME_BITS-1:0] frame_s;
    logic                  wait_done_s, launch_s, load_s;
    logic                  rise_tick_s, fall_tick_s, sclk_s;

    spi_clkgen #(.CLKDIV(clkdiv)) u_clkgen (
        .clk_i       (clk),
        .rst_i       (reset),
        .en_i        (state_q == SHIFT),
        .launch_i    (launch_s),
        .rise_tick_o (rise_tick_s),
        .fall_tick_o (fall_tick_s),
        .sclk_o      (sclk_s)
    );

    // Next-state logic for the frame sequencer, shift registers and pin registers.
    always_comb begin
        wait_done_s = (wait_q == WAIT_MAX);
        launch_s    = (state_q == SETUP) && wait_done_s;
        frame_s     = {rw, addr, rw ? wdata : {width{1'b0}}};
        load_s      = start && ((state_q == IDLE) || ((state_q == GAP) && wait_done_s));

        state_d = state_q;
        wait_d  = wait_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        rw_d    = rw_q;
        busy_d  = busy_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;

        if (load_s) begin
            state_d = SETUP;
            wait_d  = {CW{1'b0}};
            bit_d   = {BW{1'b0}};
            tx_d    = frame_s;
            rx_d    = {width{1'b0}};
            rw_d    = rw;
            busy_d  = 1'b1;
            cs_d    = 1'b0;
            mosi_d  = frame_s[WR_BIT];
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                SETUP: begin
                    if (wait_done_s) begin
                        state_d = SHIFT;
                        wait_d  = {CW{1'b0}};
                    end else begin
                        wait_d  = wait_q + CW'(1'b1);
                    end
                end
                SHIFT: begin
                    // Only bits arriving during the data byte are kept.
                    if (rise_tick_s && (bit_q >= RX_FIRST)) begin
                        rx_d = {rx_q[width-2:0], miso};
                    end else begin
                        rx_d = rx_q;
                    end
                    if (fall_tick_s && (bit_q == LAST_BIT)) begin
                        state_d = HOLD;
                        bit_d   = {BW{1'b0}};
                        mosi_d  = 1'b0;
                    end else if (fall_tick_s) begin
                        bit_d   = bit_q + BW'(1'b1);
                        tx_d    = {tx_q[FRAME_BITS-2:0], 1'b0};
                        mosi_d  = tx_q[FRAME_BITS-2];
                    end else begin
                        bit_d   = bit_q;
                    end
                end
                HOLD: begin
                    if (wait_done_s) begin
                        state_d = GAP;
                        wait_d  = {CW{1'b0}};
                        cs_d    = 1'b1;
                        done_d  = 1'b1;
                        rdata_d = rw_q ? rdata_q : rx_q;
                    end else begin
                        wait_d  = wait_q + CW'(1'b1);
                    end
                end
                GAP: begin
                    if (wait_done_s) begin
                        state_d = IDLE;
                        wait_d  = {CW{1'b0}};
                        busy_d  = 1'b0;
                    end else begin
                        wait_d  = wait_q + CW'(1'b1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    wait_d  = {CW{1'b0}};
                    bit_d   = {BW{1'b0}};
                    busy_d  = 1'b0;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= {CW{1'b0}};
            bit_q   <= {BW{1'b0}};
            tx_q    <= {FRAME_BITS{1'b0}};
            rx_q    <= {width{1'b0}};
            rdata_q <= {width{1'b0}};
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign sclk  = sclk_s;
    assign cs    = cs_q;
    assign mosi  = mosi_q;

endmodule
